// File: rtl/digit_edit_sequencer.sv
// rtl/digit_edit_sequencer.sv - encoder/button driven digit edit sequencer for clock and alarm setting
// Optional inactivity timeout is compiled in with DIGIT_EDIT_TIMEOUT_EN.
module digit_edit_sequencer #(
  parameter int TIMEOUT_TICKS = 30,
  parameter int BLINK_TICKS   = 1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Tick,
  input  logic       i_Button_Press,
  input  logic       i_Enc_CW,
  input  logic       i_Enc_CCW,
  input  logic       i_Cancel,
  input  logic       i_Change_Alarm,
  output logic       o_Encoder_Enable,
  output logic       o_Target_Alarm,
  output logic [2:0] o_Edit_Digit,
  output logic [5:0] o_Digit_Inc,
  output logic [5:0] o_Digit_Dec,
  output logic       o_Blink,
  output logic       o_Edit_Done,
  output logic       o_Edit_Abort
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  localparam logic [2:0] CURSOR_TOP = 3'd5;
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);

  state_t      state_q, state_d;
  logic [2:0]  cursor_q, cursor_d;
  logic        target_q, target_d;
  logic [5:0]  inc_q, inc_d;
  logic [5:0]  dec_q, dec_d;
  logic        blink_q, blink_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        leave_edit;
  logic [5:0]  cursor_onehot;

`ifdef DIGIT_EDIT_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_TICKS);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          activity;

  // A valid rotation or any press that survives cancel priority restarts the idle count.
  assign activity = (state_q == ST_EDIT) && !i_Cancel &&
                    (i_Button_Press || (i_Enc_CW ^ i_Enc_CCW));
`endif

  assign cursor_onehot = 6'b000001 << cursor_q;

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    target_d    = target_q;
    inc_d       = 6'b000000;
    dec_d       = 6'b000000;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    leave_edit  = 1'b0;
`ifdef DIGIT_EDIT_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cursor_d = CURSOR_TOP;
        blink_d  = 1'b0;
        if (!i_Cancel && i_Button_Press) begin
          state_d     = ST_EDIT;
          target_d    = i_Change_Alarm;
          blink_d     = 1'b1;
          blink_cnt_d = 8'd0;
`ifdef DIGIT_EDIT_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end
      end

      ST_EDIT: begin
        if (i_Tick) begin
          if (blink_cnt_q >= BLINK_LAST) begin
            blink_cnt_d = 8'd0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
        end

        if (i_Cancel) begin
          leave_edit = 1'b1;
          abort_d    = 1'b1;
        end else if (i_Button_Press) begin
          if (cursor_q != 3'd0) begin
            cursor_d    = cursor_q - 3'd1;
            blink_d     = 1'b1;
            blink_cnt_d = 8'd0;
          end else begin
            leave_edit = 1'b1;
            done_d     = 1'b1;
          end
        end else if (i_Enc_CW && !i_Enc_CCW) begin
          inc_d = cursor_onehot;
        end else if (i_Enc_CCW && !i_Enc_CW) begin
          dec_d = cursor_onehot;
        end

`ifdef DIGIT_EDIT_TIMEOUT_EN
        // Ticks coinciding with activity are not counted.
        if (activity) begin
          tmo_d = '0;
        end else if (i_Tick) begin
          if (tmo_q >= TMO_LAST) begin
            leave_edit = 1'b1;
            abort_d    = 1'b1;
          end
          tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        end
`endif

        if (leave_edit) begin
          state_d     = ST_IDLE;
          cursor_d    = CURSOR_TOP;
          blink_d     = 1'b0;
          blink_cnt_d = 8'd0;
`ifdef DIGIT_EDIT_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      cursor_q    <= CURSOR_TOP;
      target_q    <= 1'b0;
      inc_q       <= 6'b000000;
      dec_q       <= 6'b000000;
      blink_q     <= 1'b0;
      blink_cnt_q <= 8'd0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
`ifdef DIGIT_EDIT_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      target_q    <= target_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
`ifdef DIGIT_EDIT_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign o_Encoder_Enable = (state_q == ST_EDIT);
  assign o_Target_Alarm   = target_q;
  assign o_Edit_Digit     = cursor_q;
  assign o_Digit_Inc      = inc_q;
  assign o_Digit_Dec      = dec_q;
  assign o_Blink          = blink_q;
  assign o_Edit_Done      = done_q;
  assign o_Edit_Abort     = abort_q;

endmodule

// File: doc/digit_edit_sequencer.md
# digit_edit_sequencer

Sequences manual clock/alarm setting from the rotary encoder and its push button. Walks a cursor across the six time digits, turns encoder detents into single-cycle increment/decrement requests for the selected digit, and drives the edit-active level into the master controller's time FSM. Also generates the cursor blink and an inactivity timeout, and latches whether the edit targets the clock or the alarm.

## Interface
- `TIMEOUT_TICKS`, default 30: number of `i_Tick` pulses with no activity before an edit aborts; legal range 2..1023.
- `BLINK_TICKS`, default 1: number of `i_Tick` pulses per blink phase; legal range 1..255.
- `i_Clk` input 1: system clock.
- `i_Reset` input 1: synchronous, active-high reset.
- `i_Tick` input 1: one-cycle timebase strobe, nominally 2 Hz.
- `i_Button_Press` input 1: debounced one-cycle press pulse.
- `i_Enc_CW` input 1: one-cycle clockwise detent pulse.
- `i_Enc_CCW` input 1: one-cycle counter-clockwise detent pulse.
- `i_Cancel` input 1: one-cycle abort request.
- `i_Change_Alarm` input 1: level; 1 means edit the alarm, 0 means edit the time.
- `o_Encoder_Enable` output 1: high while editing.
- `o_Target_Alarm` output 1: `i_Change_Alarm` latched at edit entry.
- `o_Edit_Digit` output 3: cursor index.
- `o_Digit_Inc` output 6: one-hot increment pulse.
- `o_Digit_Dec` output 6: one-hot decrement pulse.
- `o_Blink` output 1: cursor blink phase.
- `o_Edit_Done` output 1: one-cycle pulse on normal completion.
- `o_Edit_Abort` output 1: one-cycle pulse on cancel or timeout.

## Operation
- Digit index map: 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens, 4 = hours ones, 5 = hours tens.
- The FSM has two states, IDLE and EDIT.
- **IDLE:**
  - `o_Encoder_Enable`=0, `o_Edit_Digit`=5, `o_Blink`=0, and no inc/dec pulses are produced.
  - Rotation is ignored.
  - `i_Button_Press` moves the FSM to EDIT. On entry: cursor=5, `o_Target_Alarm` <= `i_Change_Alarm`, the timeout counter and blink counter clear, and `o_Blink`=1.
- **EDIT, rotation:**
  - `i_Enc_CW` alone produces `o_Digit_Inc[cursor]` for one cycle.
  - `i_Enc_CCW` alone produces `o_Digit_Dec[cursor]` for one cycle.
  - CW and CCW in the same cycle are both dropped and do not count as activity.
- **EDIT, button:**
  - If cursor>0, the cursor decrements and `o_Blink` is forced to 1 with the blink counter cleared.
  - If cursor=0, the FSM returns to IDLE and pulses `o_Edit_Done`.
- **EDIT, cancel:** `i_Cancel` returns the FSM to IDLE and pulses `o_Edit_Abort`.
- **Event priority (highest first):** `i_Reset` > `i_Cancel` > `i_Button_Press` > rotation. A lower-priority event in the same cycle is discarded.
- **Activity:** a valid rotation or a button press clears the timeout counter.
- **Blink:** `o_Blink` toggles after every `BLINK_TICKS` ticks while in EDIT.
- **Target latch:** `o_Target_Alarm` stays constant for the whole edit; changes to `i_Change_Alarm` during EDIT are ignored. It holds its last value in IDLE.
- **Timeout counter:** width is ceil(log2(`TIMEOUT_TICKS`+1)) bits and saturates without wrap. Blink counter is 8 bits.

## Timing
- All outputs are registered.
- An input pulse in cycle N produces its response (inc/dec pulse, cursor change, state change, done/abort pulse) in cycle N+1.
- At most one bit in total across `o_Digit_Inc` and `o_Digit_Dec` is high in any cycle.
- The IDLE to EDIT entry press produces no inc/dec pulse.
- Reset values: state=IDLE, `o_Encoder_Enable`=0, `o_Target_Alarm`=0, `o_Edit_Digit`=5, `o_Digit_Inc`=0, `o_Digit_Dec`=0, `o_Blink`=0, `o_Edit_Done`=0, `o_Edit_Abort`=0, all counters=0.
- Reset during EDIT returns to IDLE on the next edge with no done/abort pulse.
- A tick arriving in the same cycle as activity does not count toward the timeout.

## Configuration
- Macro: `DIGIT_EDIT_TIMEOUT_EN`.
- **Defined:** in EDIT, the `TIMEOUT_TICKS`-th consecutive tick without activity returns the FSM to IDLE and pulses `o_Edit_Abort` one cycle later.
- **Undefined:**
  - The timeout counter and its logic are removed.
  - EDIT exits only via the button at cursor 0, via `i_Cancel`, or via reset.
  - `o_Edit_Abort` is driven only by `i_Cancel`.

## Test plan
Bench parameters: `TIMEOUT_TICKS`=4, `BLINK_TICKS`=2. All scenarios except 5 run with `DIGIT_EDIT_TIMEOUT_EN` defined.
1. Reset, then 6 button presses, with `i_Change_Alarm`=1 set before the first press -> `o_Edit_Digit` steps 5,4,3,2,1,0; the 6th press gives `o_Edit_Done`=1 for one cycle and `o_Encoder_Enable` falls; `o_Target_Alarm`=1 throughout.
2. Enter EDIT; 2 presses (cursor=3); CW, CW, CCW -> `o_Digit_Inc`=6'b001000 for two single cycles, then `o_Digit_Dec`=6'b001000 for one cycle, each one cycle after its input.
3. In EDIT, CW and CCW in the same cycle, then button plus CW in the same cycle -> no inc/dec pulse in either case; cursor 5 -> 4.
4. In EDIT, 4 ticks with no activity -> `o_Edit_Abort` pulses and the FSM returns to IDLE. A CW on tick 3 instead restarts the count, so the abort occurs 4 ticks after that CW. `o_Blink` toggles every 2 ticks while in EDIT.
5. Rebuild without `DIGIT_EDIT_TIMEOUT_EN`; 20 ticks idle in EDIT -> still in EDIT. `i_Cancel` -> `o_Edit_Abort` pulse and IDLE.
6. Assert `i_Reset` mid-edit (cursor=2) -> next cycle all outputs at reset values, `o_Edit_Digit`=5, and no done/abort pulse.
